// File: rtl/fmc_adc_tpg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fmc_adc_tpg_pkg
// Purpose  : Shared types and helpers for the ADC test-pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
package fmc_adc_tpg_pkg;

    localparam int c_TPG_MAX_DW = 16;

    typedef enum logic [1:0] {
        TPG_CONST = 2'd0,
        TPG_RAMP  = 2'd1,
        TPG_TRI   = 2'd2,
        TPG_RSVD  = 2'd3
    } t_tpg_mode;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        ERR   = 2'd3
    } t_tpg_fsm;

    // Fields sized for the widest sample; narrower instances use the low bits.
    typedef struct packed {
        t_tpg_mode                 mode;
        logic [c_TPG_MAX_DW-1:0]   step;
        logic [c_TPG_MAX_DW-1:0]   lo;
        logic [c_TPG_MAX_DW-1:0]   hi;
    } t_tpg_cfg;

    function automatic int unsigned f_ch_lsb(input int unsigned ch, input int unsigned dw);
        return ch * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmc_adc_tpg_chan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fmc_adc_tpg_chan
// Purpose  : One channel: value, direction, init clamp and wrap/reversal pulse.
// Revision : 1.0 - initial release
// ============================================================================
module fmc_adc_tpg_chan
    import fmc_adc_tpg_pkg::*;
#(
    parameter int g_DATA_WIDTH = 16
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_i,
    input  logic                    load_i,
    input  logic                    advance_i,
    input  logic [1:0]              mode_i,
    input  logic [g_DATA_WIDTH-1:0] step_i,
    input  logic [g_DATA_WIDTH-1:0] lo_i,
    input  logic [g_DATA_WIDTH-1:0] hi_i,
    input  logic [g_DATA_WIDTH-1:0] init_i,
    output logic [g_DATA_WIDTH-1:0] value_o,
    output logic                    wrap_o
);

    // Two guard bits: value + full-scale unsigned step cannot overflow.
    localparam int c_EW = g_DATA_WIDTH + 2;

    logic signed [g_DATA_WIDTH-1:0] r_value;
    logic signed [g_DATA_WIDTH-1:0] w_value_nxt;
    logic                           r_dir_dn;
    logic                           w_dir_dn_nxt;
    logic                           r_wrap;
    logic                           w_wrap_nxt;

    logic signed [c_EW-1:0] w_v;
    logic signed [c_EW-1:0] w_lo;
    logic signed [c_EW-1:0] w_hi;
    logic signed [c_EW-1:0] w_init;
    logic signed [c_EW-1:0] w_step;
    logic signed [c_EW-1:0] w_sum;
    logic signed [c_EW-1:0] w_dif;

    assign w_v    = c_EW'(r_value);
    assign w_lo   = c_EW'($signed(lo_i));
    assign w_hi   = c_EW'($signed(hi_i));
    assign w_init = c_EW'($signed(init_i));
    assign w_step = $signed(c_EW'(step_i));
    assign w_sum  = w_v + w_step;
    assign w_dif  = w_v - w_step;

    always_comb begin
        w_value_nxt  = r_value;
        w_dir_dn_nxt = r_dir_dn;
        w_wrap_nxt   = 1'b0;
        if (load_i) begin
            w_dir_dn_nxt = 1'b0;
            if (w_init > w_hi)
                w_value_nxt = hi_i;
            else if (w_init < w_lo)
                w_value_nxt = lo_i;
            else
                w_value_nxt = init_i;
        end else if (advance_i) begin
            case (t_tpg_mode'(mode_i))
                TPG_RAMP: begin
                    if (w_sum > w_hi) begin
                        w_value_nxt = lo_i;
                        w_wrap_nxt  = 1'b1;
                    end else begin
                        w_value_nxt = w_sum[g_DATA_WIDTH-1:0];
                    end
                end
                TPG_TRI: begin
                    if (!r_dir_dn) begin
                        if (w_sum > w_hi) begin
                            w_value_nxt  = hi_i;
                            w_dir_dn_nxt = 1'b1;
                            w_wrap_nxt   = 1'b1;
                        end else begin
                            w_value_nxt = w_sum[g_DATA_WIDTH-1:0];
                        end
                    end else begin
                        if (w_dif < w_lo) begin
                            w_value_nxt  = lo_i;
                            w_dir_dn_nxt = 1'b0;
                            w_wrap_nxt   = 1'b1;
                        end else begin
                            w_value_nxt = w_dif[g_DATA_WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_value  <= '0;
            r_dir_dn <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_value  <= w_value_nxt;
            r_dir_dn <= w_dir_dn_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    assign value_o = r_value;
    assign wrap_o  = r_wrap;

endmodule
`default_nettype wire

// File: rtl/fmc_adc_test_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fmc_adc_test_pattern_gen
// Purpose  : Multi-channel constant/ramp/triangle ADC test-pattern source.
// Revision : 1.0 - initial release
// ============================================================================
module fmc_adc_test_pattern_gen
    import fmc_adc_tpg_pkg::*;
#(
    parameter int g_NB_CHANNELS = 4,
    parameter int g_DATA_WIDTH  = 16
) (
    input  logic                                  sys_clk_i,
    input  logic                                  sys_rst_i,
    input  logic                                  enable_i,
    input  logic                                  sample_ce_i,
    input  logic [1:0]                            mode_i,
    input  logic [g_DATA_WIDTH-1:0]               step_i,
    input  logic [g_DATA_WIDTH-1:0]               limit_lo_i,
    input  logic [g_DATA_WIDTH-1:0]               limit_hi_i,
    input  logic [g_NB_CHANNELS*g_DATA_WIDTH-1:0] ch_init_i,
    output logic [g_NB_CHANNELS*g_DATA_WIDTH-1:0] data_o,
    output logic                                  valid_o,
    output logic [g_NB_CHANNELS-1:0]              wrap_o,
    output logic                                  running_o,
    output logic                                  cfg_err_o
);

    localparam int c_DW    = g_DATA_WIDTH;
    localparam int c_BUS_W = g_NB_CHANNELS * g_DATA_WIDTH;

    t_tpg_fsm           r_state;
    t_tpg_fsm           w_state_nxt;
    t_tpg_cfg           r_cfg;
    logic [c_BUS_W-1:0] r_init;
    logic               r_en_d;
    logic               r_valid;
    logic               r_cfg_err;
    logic               w_rise;
    logic               w_cfg_bad;
    logic               w_latch;
    logic               w_load;
    logic               w_adv;

    assign w_rise    = enable_i & ~r_en_d;
    assign w_cfg_bad = $signed(r_cfg.lo[c_DW-1:0]) > $signed(r_cfg.hi[c_DW-1:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_latch     = 1'b1;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (w_cfg_bad) begin
                    w_state_nxt = ERR;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // A strobe coinciding with the enable drop still yields its sample.
                w_adv = sample_ce_i;
                if (!enable_i)
                    w_state_nxt = IDLE;
            end
            ERR: begin
                if (!enable_i)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state   <= IDLE;
            r_en_d    <= 1'b0;
            r_valid   <= 1'b0;
            r_cfg_err <= 1'b0;
            r_cfg     <= '0;
            r_init    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en_d  <= enable_i;
            r_valid <= w_adv;
            if (w_latch) begin
                r_cfg.mode <= t_tpg_mode'(mode_i);
                r_cfg.step <= c_TPG_MAX_DW'(step_i);
                r_cfg.lo   <= c_TPG_MAX_DW'(limit_lo_i);
                r_cfg.hi   <= c_TPG_MAX_DW'(limit_hi_i);
                r_init     <= ch_init_i;
            end
            if (r_state == CHECK)
                r_cfg_err <= w_cfg_bad;
        end
    end

    generate
        for (genvar i = 0; i < g_NB_CHANNELS; i++) begin : g_chan
            fmc_adc_tpg_chan #(
                .g_DATA_WIDTH (g_DATA_WIDTH)
            ) u_chan (
                .sys_clk_i (sys_clk_i),
                .sys_rst_i (sys_rst_i),
                .load_i    (w_load),
                .advance_i (w_adv),
                .mode_i    (r_cfg.mode),
                .step_i    (r_cfg.step[c_DW-1:0]),
                .lo_i      (r_cfg.lo[c_DW-1:0]),
                .hi_i      (r_cfg.hi[c_DW-1:0]),
                .init_i    (r_init[f_ch_lsb(i, c_DW) +: c_DW]),
                .value_o   (data_o[f_ch_lsb(i, c_DW) +: c_DW]),
                .wrap_o    (wrap_o[i])
            );
        end
    endgenerate

    assign valid_o   = r_valid;
    assign running_o = (r_state == RUN);
    assign cfg_err_o = r_cfg_err;

endmodule
`default_nettype wire
